// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: stage state encoding and stall counter width.
// Pure declarations; no timing or flow-control behaviour of its own.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int STALL_CNT_W = 32;

  // The state encoding doubles as the entry count; keep this mapping explicit anyway.
  function automatic logic [1:0] occ_of(input pipe_state_t s);
    logic [1:0] occ;
    case (s)
      PS_ONE:  occ = 2'd1;
      PS_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Count updates one cycle after inc/clr; no backpressure, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer, flush and stall counter.
// Latency 1 cycle when empty; SKID=1 gives a registered in_ready, SKID=0 a combinational one.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int SKID       = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   flush,
  input  logic                   cnt_clr,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t           state_q;
  pipe_state_t           state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q;
  logic [DATA_WIDTH-1:0] main_data_q;
  logic                  head_vld;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  stall_inc;

  assign head_vld  = (state_q != PS_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = head_vld && out_ready;
  assign stall_inc = head_vld && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic                  in_ready_q;
      logic [CTRL_WIDTH-1:0] skid_ctrl_q;
      logic [DATA_WIDTH-1:0] skid_data_q;

      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = PS_EMPTY;
        end else begin
          case (state_q)
            PS_EMPTY: if (in_xfer) state_d = PS_ONE;
            PS_ONE: begin
              if (in_xfer && !out_xfer)      state_d = PS_TWO;
              else if (!in_xfer && out_xfer) state_d = PS_EMPTY;
            end
            PS_TWO:   if (out_xfer) state_d = PS_ONE;
            default:  state_d = PS_EMPTY;
          endcase
        end
      end

      // Ready is looked up from the next state so it never depends on out_ready in the same cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != PS_TWO);
        end
      end

      assign in_ready = in_ready_q;

      // Main register is always the head; skid only ever feeds main.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_ctrl_q <= '0;
          main_data_q <= '0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end else if (!flush) begin
          case (state_q)
            PS_EMPTY: begin
              if (in_xfer) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
              end
            end
            PS_ONE: begin
              if (in_xfer && out_xfer) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
              end else if (in_xfer) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
              end
            end
            PS_TWO: begin
              if (out_xfer) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
              end
            end
            default: ;
          endcase
        end
      end
    end else begin : g_noskid
      assign in_ready = !head_vld || out_ready;

      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = PS_EMPTY;
        end else begin
          case (state_q)
            PS_EMPTY: if (in_xfer) state_d = PS_ONE;
            PS_ONE:   if (out_xfer && !in_xfer) state_d = PS_EMPTY;
            default:  state_d = PS_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_ctrl_q <= '0;
          main_data_q <= '0;
        end else if (!flush && in_xfer) begin
          main_ctrl_q <= in_ctrl;
          main_data_q <= in_data;
        end
      end
    end
  endgenerate

  // Payload holds its last value on bubbles; control bits must read as zero.
  always_comb begin
    out_valid = head_vld;
    out_ctrl  = head_vld ? main_ctrl_q : '0;
    out_data  = main_data_q;
    occupancy = occ_of(state_q);
  end

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid (SKID=1) and a plain (SKID=0) stage with identical stimulus
// and compares both against queue-based reference models every cycle.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        cnt_clr;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0]  out_ctrl1, out_ctrl0;
  logic [63:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;
  logic [31:0] stall1, stall0;

  int checks = 0;
  int errors = 0;

  // Reference state: each queue entry is {ctrl, data}, head at index 0.
  logic [71:0] q_s1[$];
  logic [71:0] q_s0[$];
  logic [63:0] last_s1, last_s0;
  logic [31:0] cnt_s1, cnt_s0;

  pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .flush(flush), .cnt_clr(cnt_clr),
    .occupancy(occ1), .stall_cnt(stall1)
  );

  pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .flush(flush), .cnt_clr(cnt_clr),
    .occupancy(occ0), .stall_cnt(stall0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] ec1, ec0;
    logic [63:0] ed1, ed0;
    ec1 = (q_s1.size() != 0) ? q_s1[0][71:64] : 8'h00;
    ed1 = (q_s1.size() != 0) ? q_s1[0][63:0]  : last_s1;
    ec0 = (q_s0.size() != 0) ? q_s0[0][71:64] : 8'h00;
    ed0 = (q_s0.size() != 0) ? q_s0[0][63:0]  : last_s0;
    chk("s1_in_ready",  64'(in_ready1),  64'(q_s1.size() < 2));
    chk("s1_out_valid", 64'(out_valid1), 64'(q_s1.size() != 0));
    chk("s1_out_ctrl",  64'(out_ctrl1),  64'(ec1));
    chk("s1_out_data",  out_data1,       ed1);
    chk("s1_occupancy", 64'(occ1),       64'(q_s1.size()));
    chk("s1_stall_cnt", 64'(stall1),     64'(cnt_s1));
    chk("s0_in_ready",  64'(in_ready0),  64'((q_s0.size() == 0) || out_ready));
    chk("s0_out_valid", 64'(out_valid0), 64'(q_s0.size() != 0));
    chk("s0_out_ctrl",  64'(out_ctrl0),  64'(ec0));
    chk("s0_out_data",  out_data0,       ed0);
    chk("s0_occupancy", 64'(occ0),       64'(q_s0.size()));
    chk("s0_stall_cnt", 64'(stall0),     64'(cnt_s0));
  endtask

  task automatic clear_models();
    q_s1.delete();
    q_s0.delete();
    last_s1 = '0;
    last_s0 = '0;
    cnt_s1  = '0;
    cnt_s0  = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the models at the rising edge.
  task automatic step(input logic iv, input logic [7:0] ic, input logic [63:0] id,
                      input logic ordy, input logic fl, input logic clr);
    logic in_x1, out_x1, st1, in_x0, out_x0, st0;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    #1;
    check_all();
    in_x1  = iv && (q_s1.size() < 2);
    out_x1 = (q_s1.size() != 0) && ordy;
    st1    = (q_s1.size() != 0) && !ordy;
    in_x0  = iv && ((q_s0.size() == 0) || ordy);
    out_x0 = (q_s0.size() != 0) && ordy;
    st0    = (q_s0.size() != 0) && !ordy;
    @(posedge clk);
    if (fl) q_s1.delete();
    else begin
      if (out_x1) void'(q_s1.pop_front());
      if (in_x1)  q_s1.push_back({ic, id});
    end
    if (fl) q_s0.delete();
    else begin
      if (out_x0) void'(q_s0.pop_front());
      if (in_x0)  q_s0.push_back({ic, id});
    end
    if (q_s1.size() != 0) last_s1 = q_s1[0][63:0];
    if (q_s0.size() != 0) last_s0 = q_s0[0][63:0];
    if (clr) cnt_s1 = '0;
    else if (st1 && cnt_s1 != 32'hFFFF_FFFF) cnt_s1 = cnt_s1 + 32'd1;
    if (clr) cnt_s0 = '0;
    else if (st0 && cnt_s0 != 32'hFFFF_FFFF) cnt_s0 = cnt_s0 + 32'd1;
    @(negedge clk);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_s1_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_s1_occupancy", 64'(occ1),       64'd0);
    chk("rst_s1_stall_cnt", 64'(stall1),     64'd0);
    chk("rst_s1_in_ready",  64'(in_ready1),  64'd1);
    chk("rst_s1_out_ctrl",  64'(out_ctrl1),  64'd0);
    chk("rst_s1_out_data",  out_data1,       64'd0);
    chk("rst_s0_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_s0_occupancy", 64'(occ0),       64'd0);
    chk("rst_s0_in_ready",  64'(in_ready0),  64'd1);
    clear_models();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    clear_models();
    @(negedge clk);
    async_reset();

    // Back-to-back streaming with the sink always ready.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 64'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);

    // Sink stalls for five cycles while the source keeps offering, then drains.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 64'(100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush a full stage while a new entry is offered; that entry must vanish.
    step(1'b1, 8'h11, 64'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 64'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 64'hAA, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h33, 64'h33, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h44, 64'h44, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0);

    // Sink ready toggling every cycle.
    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom}, 1'(i % 2 == 0), 1'b0, 1'b0);

    // Random traffic with occasional flush and counter clear.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 31) == 0));

    // Reset with the skid stage full.
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 64'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h66, 64'h66, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_s1_occupancy", 64'(occ1), 64'd2);
    async_reset();
    step(1'b1, 8'h77, 64'h77, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0);

    // Counter saturation from a preloaded near-max value, then clear during a stall.
    force dut1.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut1.u_stall_cnt.count_q;
    cnt_s1 = 32'hFFFF_FFFE;
    step(1'b1, 8'h88, 64'h88, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_s1_stall_cnt", 64'(stall1), 64'h0000_0000_FFFF_FFFF);
    step(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
